// File: rtl/twosum_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : twosum_arb_ctrl
// Purpose  : Round-robin arbiter that shares one fixed-latency twosum_start
//            datapath between two requesters. Each accepted group of four FP
//            elements is issued to the datapath one cycle after the
//            handshake. A {valid, id} tag travels alongside the group, and the
//            datapath result is returned to its owning requester in issue
//            order. Each requester has an outstanding-group limit.
// Ports    : clk_i, rst_ni          - clock, asynchronous active-low reset
//            req_valid_i/ready_o   - per-requester group handshake
//            req_data_i            - two packed groups {e3,e2,e1,e0}
//            dp_e0_o..dp_e3_o      - registered operands to the datapath
//            dp_sum_*_i/error_*_i  - datapath results, DP_LAT after issue
//            res_valid_o/id_o/data_o - result stream (no backpressure)
//            idle_o                - nothing in flight and nothing requested
// Revision : 1.0 - initial release
// ============================================================================
module twosum_arb_ctrl #(
  parameter  int EXP_WIDTH_I  = 5,
  parameter  int MANT_WIDTH_I = 2,
  parameter  int DP_LAT       = 3,
  parameter  int MAX_OUT      = 4,
  localparam int BIT_WIDTH_I  = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [2*4*BIT_WIDTH_I-1:0] req_data_i,
  output logic [BIT_WIDTH_I-1:0]     dp_e0_o,
  output logic [BIT_WIDTH_I-1:0]     dp_e1_o,
  output logic [BIT_WIDTH_I-1:0]     dp_e2_o,
  output logic [BIT_WIDTH_I-1:0]     dp_e3_o,
  input  logic [BIT_WIDTH_I-1:0]     dp_sum_a_i,
  input  logic [BIT_WIDTH_I-1:0]     dp_sum_b_i,
  input  logic [BIT_WIDTH_I-1:0]     dp_error_a_i,
  input  logic [BIT_WIDTH_I-1:0]     dp_error_b_i,
  output logic                       res_valid_o,
  output logic                       res_id_o,
  output logic [4*BIT_WIDTH_I-1:0]   res_data_o,
  output logic                       idle_o
);

  localparam int                CNT_W   = $clog2(MAX_OUT + 1);
  localparam int                GRP_W   = 4 * BIT_WIDTH_I;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [2];
  logic             prio;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             hs;
  logic             grant_id;
  logic [GRP_W-1:0] sel_group;
  logic [1:0]       inc;
  logic [1:0]       dec;
  logic [DP_LAT:0]  tag_valid;
  logic [DP_LAT:0]  tag_id;

  // --------------------------------------------------------------------------
  // Arbitration. Ready is forced low while reset is asserted, because the
  // counters read zero then and would otherwise let a request through.
  // --------------------------------------------------------------------------
  always_comb begin
    eligible[0] = req_valid_i[0] && (cnt[0] < CNT_MAX);
    eligible[1] = req_valid_i[1] && (cnt[1] < CNT_MAX);
    grant       = 2'b00;
    if (rst_ni) begin
      if (eligible == 2'b11) begin
        grant = prio ? 2'b10 : 2'b01;
      end else begin
        grant = eligible;
      end
    end
  end

  assign req_ready_o = grant;
  assign hs          = |grant;
  assign grant_id    = grant[1];
  assign sel_group   = grant_id ? req_data_i[2*GRP_W-1:GRP_W] : req_data_i[GRP_W-1:0];

  // --------------------------------------------------------------------------
  // Priority pointer: it moves to the other requester after every handshake.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio <= 1'b0;
    end else if (hs) begin
      prio <= ~grant_id;
    end
  end

  // --------------------------------------------------------------------------
  // Operand register. Idle cycles drive zeros so that the datapath never sees
  // stale operands.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dp_e0_o <= '0;
      dp_e1_o <= '0;
      dp_e2_o <= '0;
      dp_e3_o <= '0;
    end else if (hs) begin
      dp_e0_o <= sel_group[0*BIT_WIDTH_I +: BIT_WIDTH_I];
      dp_e1_o <= sel_group[1*BIT_WIDTH_I +: BIT_WIDTH_I];
      dp_e2_o <= sel_group[2*BIT_WIDTH_I +: BIT_WIDTH_I];
      dp_e3_o <= sel_group[3*BIT_WIDTH_I +: BIT_WIDTH_I];
    end else begin
      dp_e0_o <= '0;
      dp_e1_o <= '0;
      dp_e2_o <= '0;
      dp_e3_o <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipeline. Stage 0 lines up with the operand register, so the head
  // stage lines up with the datapath outputs. Bubbles carry id 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= hs;
      tag_id[0]    <= hs & grant_id;
      for (int k = 1; k <= DP_LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  assign res_valid_o = tag_valid[DP_LAT];
  assign res_id_o    = tag_id[DP_LAT];
  assign res_data_o  = {dp_error_b_i, dp_error_a_i, dp_sum_b_i, dp_sum_a_i};

  // --------------------------------------------------------------------------
  // Outstanding counters. A grant requires cnt < MAX_OUT, and a retire only
  // happens for a group that was counted in. Together these keep each counter
  // inside 0..MAX_OUT without explicit saturation logic.
  // --------------------------------------------------------------------------
  always_comb begin
    inc = grant;
    dec = 2'b00;
    if (res_valid_o) begin
      dec[res_id_o] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({inc[i], dec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
          2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  assign idle_o = (cnt[0] == '0) && (cnt[1] == '0) && (req_valid_i == 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_twosum_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_twosum_arb_ctrl
// Purpose  : Scoreboard bench for twosum_arb_ctrl (default parameters). The
//            stimulus pushes the expected result and its due cycle for every
//            grant it expects. A monitor pops an entry on each res_valid_o and
//            compares the result id, data and arrival cycle. A small fixed
//            DP_LAT pipeline stands in for the twosum_start datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twosum_arb_ctrl;

  localparam int BW     = 8;
  localparam int DP_LAT = 3;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [BW-1:0] dp_e0, dp_e1, dp_e2, dp_e3;
  logic [BW-1:0] dp_sum_a, dp_sum_b, dp_error_a, dp_error_b;
  logic        res_valid;
  logic        res_id;
  logic [31:0] res_data;
  logic        idle;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [31:0] dp_pipe [DP_LAT];

  twosum_arb_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .dp_e0_o      (dp_e0),
    .dp_e1_o      (dp_e1),
    .dp_e2_o      (dp_e2),
    .dp_e3_o      (dp_e3),
    .dp_sum_a_i   (dp_sum_a),
    .dp_sum_b_i   (dp_sum_b),
    .dp_error_a_i (dp_error_a),
    .dp_error_b_i (dp_error_b),
    .res_valid_o  (res_valid),
    .res_id_o     (res_id),
    .res_data_o   (res_data),
    .idle_o       (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in datapath function: {e1^e3, e0^e2, e2+e3, e0+e1}
  function automatic logic [31:0] model(input logic [31:0] g);
    logic [7:0] e0, e1, e2, e3;
    e0 = g[7:0];
    e1 = g[15:8];
    e2 = g[23:16];
    e3 = g[31:24];
    return {e1 ^ e3, e0 ^ e2, 8'(e2 + e3), 8'(e0 + e1)};
  endfunction

  always @(posedge clk) begin
    dp_pipe[0] <= {dp_e3, dp_e2, dp_e1, dp_e0};
    for (int k = 1; k < DP_LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign {dp_error_b, dp_error_a, dp_sum_b, dp_sum_a} = model(dp_pipe[DP_LAT-1]);

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: detects a missing result once its due cycle has passed, and
  // compares every presented result with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_result actual=none required id=%0d data=%h due=%0d", q[0].id, q[0].data, q[0].due);
        void'(q.pop_front());
      end
      if (res_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result actual id=%0d data=%h required no result (cycle %0d)", res_id, res_data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result{cycle,id,data}", {32'(cyc), 31'd0, res_id, res_data}, {32'(e.due), 31'd0, e.id, e.data});
        end
      end
    end
  end

  // Holds inputs for one cycle, checks ready against the hand-derived grant,
  // and records the expected result when a grant is expected.
  task automatic drive(input logic [1:0] v, input logic [63:0] d, input logic [1:0] exp_rdy);
    exp_t e;
    req_valid = v;
    req_data  = d;
    @(negedge clk);
    chk("req_ready", 96'(req_ready), 96'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      e.id   = exp_rdy[1];
      e.data = model(exp_rdy[1] ? d[63:32] : d[31:0]);
      e.due  = cyc + 1 + DP_LAT;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DP_LAT + 3; i++) drive(2'b00, 64'd0, 2'b00);
    chk("idle_after_drain", 96'(idle), 96'(1));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 96'({res_valid, res_id, dp_e3, dp_e2, dp_e1, dp_e0, req_ready}), 96'(0));
    req_valid = 2'b00;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] v4 [7];
    v4 = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};

    // Single issue: operands at t+1, result at t+4, counter back to 0 at t+5.
    do_reset();
    drive(2'b01, 64'h0000_0000_0000_2010, 2'b01);
    chk("dp_operands_t+1", 96'({dp_e3, dp_e2, dp_e1, dp_e0}), 96'(32'h0000_2010));
    drive(2'b00, 64'd0, 2'b00);
    drive(2'b00, 64'd0, 2'b00);
    drive(2'b00, 64'd0, 2'b00);
    chk("res_t+4{valid,id,data}", 96'({res_valid, res_id, res_data}), 96'({1'b1, 1'b0, 32'h2010_0030}));
    chk("idle_while_in_flight", 96'(idle), 96'(0));
    drive(2'b00, 64'd0, 2'b00);
    chk("idle_t+5", 96'(idle), 96'(1));

    // Both requesting: strict alternation starting at requester 0. Priority
    // must survive five quiet cycles.
    do_reset();
    for (int i = 0; i < 7; i++)
      drive(2'b11, {32'hA0A1_A2A3 + 32'(i), 32'h1020_3040 + 32'(3 * i)}, (i % 2 == 1) ? 2'b10 : 2'b01);
    for (int i = 0; i < 5; i++) drive(2'b00, 64'd0, 2'b00);
    chk("quiet{dp_e,res_valid,idle}", 96'({dp_e3, dp_e2, dp_e1, dp_e0, res_valid, idle}), 96'({32'd0, 1'b0, 1'b1}));
    drive(2'b11, 64'h0506_0708_0102_0304, 2'b10);
    drive(2'b11, 64'h1111_2222_3333_4444, 2'b01);
    drain();

    // Requester 1 alone: four grants saturate it. Each retire reopens it on
    // the following cycle.
    do_reset();
    for (int i = 0; i < 10; i++)
      drive(2'b10, {32'h0F0E_0D0C + 32'(i * 32'h0101_0101), 32'hDEAD_BEEF}, (i == 4 || i == 9) ? 2'b00 : 2'b10);
    drain();

    // Requester 0: an issue and a retire land together at cnt=2.
    do_reset();
    for (int i = 0; i < 7; i++)
      drive(v4[i], {32'h0, 32'h4030_2010 + 32'(i)}, v4[i]);
    drain();

    // Reset with three groups in flight: everything is discarded.
    do_reset();
    drive(2'b01, 64'h0000_0000_0102_0304, 2'b01);
    drive(2'b10, 64'h0506_0708_0000_0000, 2'b10);
    drive(2'b01, 64'h0000_0000_090A_0B0C, 2'b01);
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk("async_reset_outputs", 96'({res_valid, res_id, dp_e3, dp_e2, dp_e1, dp_e0, req_ready}), 96'(0));
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) drive(2'b00, 64'd0, 2'b00);
    chk("idle_after_reset", 96'(idle), 96'(1));
    drive(2'b11, 64'h7777_7777_3344_5566, 2'b01);
    drain();

    chk("scoreboard_empty", 96'(q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/twosum_arb_ctrl.md
TWOSUM_ARB_CTRL -- requirements
Module: twosum_arb_ctrl

Interface
REQ-001 SHALL have parameter EXP_WIDTH_I, default 5, exponent width of each FP element.
REQ-002 SHALL have parameter MANT_WIDTH_I, default 2, mantissa width; BIT_WIDTH_I = 1+EXP_WIDTH_I+MANT_WIDTH_I (localparam).
REQ-003 SHALL have parameter DP_LAT, default 3, fixed cycle latency of the shared twosum_start datapath, from dp_e*_o to dp_*_i.
REQ-004 SHALL have parameter MAX_OUT, default 4, maximum in-flight groups per requester; counter width $clog2(MAX_OUT+1).
REQ-005 clk_i  input  1  single clock, rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 req_valid_i  input  2  per-requester group valid (bit i = requester i).
REQ-008 req_ready_o  output  2  per-requester accept; at most one bit high per cycle.
REQ-009 req_data_i  input  2*4*BIT_WIDTH_I  requester i group at slice i, packed {e3,e2,e1,e0}, e0 in LSBs.
REQ-010 dp_e0_o..dp_e3_o  output  BIT_WIDTH_I each  registered operands to the datapath.
REQ-011 dp_sum_a_i, dp_sum_b_i, dp_error_a_i, dp_error_b_i  input  BIT_WIDTH_I each  datapath results.
REQ-012 res_valid_o  output  1  result valid; no backpressure, sink always accepts.
REQ-013 res_id_o  output  1  requester owning the result.
REQ-014 res_data_o  output  4*BIT_WIDTH_I  {error_b,error_a,sum_b,sum_a}, sum_a in LSBs.
REQ-015 idle_o  output  1  high when no group in flight and no request pending.

Function
REQ-016 Requester i eligible when req_valid_i[i]=1 and outstanding count cnt[i] < MAX_OUT.
REQ-017 Round-robin: priority pointer prio selects preferred requester; if both eligible, grant prio; if one eligible, grant it.
REQ-018 req_ready_o[i] SHALL be 1 exactly when i is granted this cycle (combinational from valid, cnt, prio); handshake = valid & ready.
REQ-019 On a handshake, prio SHALL become the other requester next cycle; with no handshake, prio holds.
REQ-020 On handshake cycle t, the granted group SHALL be registered into dp_e0_o..dp_e3_o at t+1; on non-handshake cycles dp_e*_o SHALL be registered to all-zero.
REQ-021 A tag pipeline of depth 1+DP_LAT SHALL carry {valid, id} alongside each issue; bubbles carry valid=0.
REQ-022 res_valid_o/res_id_o SHALL be the tag pipeline head; res_valid_o rises at cycle t+1+DP_LAT for a handshake at t.
REQ-023 res_data_o SHALL equal the dp_*_i inputs combinationally, packed per REQ-014; content is don't-care when res_valid_o=0.
REQ-024 cnt[i] increments on requester i handshake, decrements when res_valid_o=1 with res_id_o=i, unchanged when both occur in the same cycle.
REQ-025 cnt[i] SHALL never exceed MAX_OUT nor underflow; a requester at MAX_OUT SHALL see req_ready_o[i]=0 even if it holds priority, and the other requester may be granted.
REQ-026 Issue throughput SHALL be one group per cycle; results return in issue order.
REQ-027 idle_o = (cnt[0]==0) & (cnt[1]==0) & (req_valid_i==0).

Reset
REQ-028 While rst_ni=0: dp_e*_o=0, tag pipeline all invalid, res_valid_o=0, res_id_o=0, cnt[0]=cnt[1]=0, prio=0, req_ready_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight groups; no res_valid_o pulse after deassertion for groups issued before reset.
REQ-030 First grant after reset with both requesters valid SHALL go to requester 0.

Verification
REQ-031 Single issue: req0 group e0=0x10,e1=0x20,e2=0,e3=0 at cycle t -> dp_e0_o=0x10 at t+1, res_valid_o=1,res_id_o=0 at t+4 (DP_LAT=3), cnt[0] back to 0 at t+5.
REQ-032 Both valid continuously for 8 cycles -> grants alternate 0,1,0,1,... one per cycle until a requester hits MAX_OUT=4, then only the other granted.
REQ-033 Only req1 valid, MAX_OUT=4, 4 accepted -> req_ready_o[1]=0 until first res_valid_o with id 1, then ready again next cycle.
REQ-034 Simultaneous retire and issue for requester 0 at cnt=2 -> cnt stays 2, no ready glitch.
REQ-035 rst_ni pulsed low with 3 groups in flight -> all outputs 0 immediately, no res_valid_o for 10 cycles after release, idle_o=1.
REQ-036 No requests for 5 cycles -> dp_e*_o=0, res_valid_o=0, idle_o=1, prio unchanged.
